// File: rtl/lfsr_bist_pkg.sv
// rtl/lfsr_bist_pkg.sv - shared widths, MISR defaults and FSM states for the LFSR BIST checker
package lfsr_bist_pkg;

   localparam int SIG_W  = 16;
   localparam int DATA_W = 8;
   localparam int IDX_W  = 9;

   localparam logic [SIG_W-1:0] MISR_POLY_DEF = 16'h1021;
   localparam logic [SIG_W-1:0] MISR_INIT_DEF = 16'h0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } bist_state_e;

endpackage

// File: rtl/lfsr_misr_step.sv
// rtl/lfsr_misr_step.sv - one combinational MISR compaction step (shift, poly feedback, fold data)
module lfsr_misr_step
   import lfsr_bist_pkg::*;
#(
   parameter logic [SIG_W-1:0] POLY = MISR_POLY_DEF
) (
   input  logic [SIG_W-1:0]  sig_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [SIG_W-1:0]  sig_o
);

   assign sig_o = {sig_i[SIG_W-2:0], 1'b0}
                ^ (sig_i[SIG_W-1] ? POLY : '0)
                ^ {{(SIG_W-DATA_W){1'b0}}, data_i};

endmodule

// File: rtl/lfsr_bist_checker.sv
// rtl/lfsr_bist_checker.sv - seeds the LFSR, compacts CYCLES samples into a MISR, reports period/stuck/pass
module lfsr_bist_checker
   import lfsr_bist_pkg::*;
#(
   parameter int               CYCLES    = 255,
   parameter logic [SIG_W-1:0] MISR_POLY = MISR_POLY_DEF,
   parameter logic [SIG_W-1:0] MISR_INIT = MISR_INIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] seed,
   input  logic [SIG_W-1:0]  golden_sig,
   input  logic [DATA_W-1:0] lfsr_d,
   output logic              seed_val,
   output logic [DATA_W-1:0] seed_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  signature,
   output logic [IDX_W-1:0]  period,
   output logic              period_found,
   output logic              stuck
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CYCLES - 1);

   bist_state_e       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SIG_W-1:0]  sig_q, sig_d, misr_next;
   logic [DATA_W-1:0] first_q, first_d, prev_q, prev_d;
   logic [DATA_W-1:0] seed_out_q, seed_out_d;
   logic [IDX_W-1:0]  wper_q, wper_d;
   logic              wfound_q, wfound_d, wstuck_q, wstuck_d;
   logic [SIG_W-1:0]  res_sig_q, res_sig_d;
   logic [IDX_W-1:0]  res_per_q, res_per_d;
   logic              res_pass_q, res_pass_d;
   logic              res_found_q, res_found_d, res_stuck_q, res_stuck_d;
   logic              in_done;

   lfsr_misr_step #(.POLY(MISR_POLY)) u_misr_step (
      .sig_i  (sig_q),
      .data_i (lfsr_d),
      .sig_o  (misr_next)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sig_d       = sig_q;
      first_d     = first_q;
      prev_d      = prev_q;
      seed_out_d  = seed_out_q;
      wper_d      = wper_q;
      wfound_d    = wfound_q;
      wstuck_d    = wstuck_q;
      res_sig_d   = res_sig_q;
      res_per_d   = res_per_q;
      res_pass_d  = res_pass_q;
      res_found_d = res_found_q;
      res_stuck_d = res_stuck_q;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               seed_out_d  = seed;
               idx_d       = '0;
               sig_d       = MISR_INIT;
               wper_d      = '0;
               wfound_d    = 1'b0;
               wstuck_d    = 1'b0;
               res_sig_d   = '0;
               res_per_d   = '0;
               res_pass_d  = 1'b0;
               res_found_d = 1'b0;
               res_stuck_d = 1'b0;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            idx_d   = '0;
            state_d = abort ? IDLE : SAMPLE;
         end
         SAMPLE: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               sig_d = misr_next;
               if (idx_q == '0) begin
                  first_d = lfsr_d;
               end else begin
                  if (lfsr_d == prev_q)
                     wstuck_d = 1'b1;
                  if (lfsr_d == first_q && !wfound_q) begin
                     wper_d   = idx_q;
                     wfound_d = 1'b1;
                  end
               end
               prev_d = lfsr_d;
               idx_d  = idx_q + 1'b1;
               if (idx_q == IDX_LAST)
                  state_d = DONE;
            end
         end
         DONE: begin
            res_sig_d   = sig_q;
            res_pass_d  = (sig_q == golden_sig);
            res_per_d   = wper_q;
            res_found_d = wfound_q;
            res_stuck_d = wstuck_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         sig_q       <= MISR_INIT;
         first_q     <= '0;
         prev_q      <= '0;
         seed_out_q  <= '0;
         wper_q      <= '0;
         wfound_q    <= 1'b0;
         wstuck_q    <= 1'b0;
         res_sig_q   <= '0;
         res_per_q   <= '0;
         res_pass_q  <= 1'b0;
         res_found_q <= 1'b0;
         res_stuck_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sig_q       <= sig_d;
         first_q     <= first_d;
         prev_q      <= prev_d;
         seed_out_q  <= seed_out_d;
         wper_q      <= wper_d;
         wfound_q    <= wfound_d;
         wstuck_q    <= wstuck_d;
         res_sig_q   <= res_sig_d;
         res_per_q   <= res_per_d;
         res_pass_q  <= res_pass_d;
         res_found_q <= res_found_d;
         res_stuck_q <= res_stuck_d;
      end
   end

   // Results are shown live from the working registers during DONE so they are valid with the done pulse.
   assign in_done      = (state_q == DONE);
   assign seed_val     = (state_q == LOAD);
   assign busy         = (state_q == LOAD) || (state_q == SAMPLE);
   assign done         = in_done;
   assign seed_out     = seed_out_q;
   assign signature    = in_done ? sig_q : res_sig_q;
   assign pass         = in_done ? (sig_q == golden_sig) : res_pass_q;
   assign period       = in_done ? wper_q : res_per_q;
   assign period_found = in_done ? wfound_q : res_found_q;
   assign stuck        = in_done ? wstuck_q : res_stuck_q;

endmodule

// File: tb/tb_lfsr_bist_checker.sv
// tb/tb_lfsr_bist_checker.sv - self-checking bench: LFSR/stub source, sample-list model, directed runs
module tb_lfsr_bist_checker;

   localparam int CYC = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  seed = 8'h00;
   logic [15:0] golden_sig = 16'h0000;
   logic [7:0]  lfsr_d;
   logic        seed_val;
   logic [7:0]  seed_out;
   logic        busy, done, pass;
   logic [15:0] signature;
   logic [8:0]  period;
   logic        period_found, stuck;

   int checks = 0;
   int failures = 0;
   bit use_stub = 1'b0;
   bit chk_en = 1'b0;

   logic [7:0] lfsr_q = 8'h00;
   int         stub_i = 0;

   always #5 clk = ~clk;

   lfsr_bist_checker #(
      .CYCLES    (CYC),
      .MISR_POLY (16'h1021),
      .MISR_INIT (16'h0000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .seed         (seed),
      .golden_sig   (golden_sig),
      .lfsr_d       (lfsr_d),
      .seed_val     (seed_val),
      .seed_out     (seed_out),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .signature    (signature),
      .period       (period),
      .period_found (period_found),
      .stuck        (stuck)
   );

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   function automatic logic [7:0] stub_val(input int i);
      case (i)
         0: return 8'h11;
         1: return 8'h22;
         2: return 8'h33;
         3: return 8'h11;
         4: return 8'h22;
         default: return 8'h5A;
      endcase
   endfunction

   // Sample source: registered LFSR or a fixed stub sequence, both restarted by seed_val.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= 8'h00;
         stub_i <= 0;
      end else if (seed_val) begin
         lfsr_q <= seed_out;
         stub_i <= 0;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
         stub_i <= (stub_i < 1000) ? stub_i + 1 : stub_i;
      end
   end

   assign lfsr_d = use_stub ? stub_val(stub_i) : lfsr_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected results straight from the sample list the run will see.
   function automatic void predict(input logic [7:0] s, input bit stub, output logic [15:0] sg,
                                   output logic [8:0] per, output bit found, output bit stk);
      logic [7:0] smp [CYC];
      logic [7:0] x;
      x = s;
      for (int i = 0; i < CYC; i++) begin
         smp[i] = stub ? stub_val(i) : x;
         x = lfsr_next(x);
      end
      sg = 16'h0000;
      for (int i = 0; i < CYC; i++)
         sg = {sg[14:0], 1'b0} ^ (sg[15] ? 16'h1021 : 16'h0000) ^ {8'h00, smp[i]};
      per = 9'd0;
      found = 1'b0;
      stk = 1'b0;
      for (int k = 1; k < CYC; k++) begin
         if (!found && smp[k] == smp[0]) begin
            per = 9'(k);
            found = 1'b1;
         end
         if (smp[k] == smp[k-1])
            stk = 1'b1;
      end
   endfunction

   // Run timeline: m_t=1 load, 2..CYC+1 sampling, CYC+2 done cycle, 0 idle.
   int          m_t = 0;
   logic [7:0]  m_seed = 8'h00;
   logic [15:0] m_exp_sig = 16'h0, m_res_sig = 16'h0;
   logic [8:0]  m_exp_per = 9'h0, m_res_per = 9'h0;
   bit          m_exp_found = 0, m_exp_stuck = 0;
   bit          m_res_found = 0, m_res_stuck = 0, m_res_pass = 0;

   always @(posedge clk or negedge rst_n) begin : model_p
      logic [15:0] es;
      logic [8:0]  ep;
      bit          ef, est;
      if (!rst_n) begin
         m_t <= 0;
         m_seed <= 8'h00;
         m_res_sig <= 16'h0;
         m_res_per <= 9'h0;
         m_res_found <= 1'b0;
         m_res_stuck <= 1'b0;
         m_res_pass <= 1'b0;
      end else if (m_t == 0) begin
         if (start && !abort) begin
            predict(seed, use_stub, es, ep, ef, est);
            m_exp_sig <= es;
            m_exp_per <= ep;
            m_exp_found <= ef;
            m_exp_stuck <= est;
            m_seed <= seed;
            m_res_sig <= 16'h0;
            m_res_per <= 9'h0;
            m_res_found <= 1'b0;
            m_res_stuck <= 1'b0;
            m_res_pass <= 1'b0;
            m_t <= 1;
         end
      end else if (abort && m_t <= CYC + 1) begin
         m_t <= 0;
      end else if (m_t == CYC + 2) begin
         m_t <= 0;
         m_res_sig <= m_exp_sig;
         m_res_per <= m_exp_per;
         m_res_found <= m_exp_found;
         m_res_stuck <= m_exp_stuck;
         m_res_pass <= (m_exp_sig == golden_sig);
      end else begin
         m_t <= m_t + 1;
      end
   end

   always @(negedge clk) begin : compare_p
      bit dn;
      if (chk_en) begin
         dn = (m_t == CYC + 2);
         chk("seed_val", 32'(seed_val), 32'(m_t == 1));
         chk("busy", 32'(busy), 32'(m_t >= 1 && m_t <= CYC + 1));
         chk("done", 32'(done), 32'(dn));
         chk("seed_out", 32'(seed_out), 32'(m_seed));
         chk("signature", 32'(signature), 32'(dn ? m_exp_sig : m_res_sig));
         chk("pass", 32'(pass), 32'(dn ? (m_exp_sig == golden_sig) : m_res_pass));
         chk("period", 32'(period), 32'(dn ? m_exp_per : m_res_per));
         chk("period_found", 32'(period_found), 32'(dn ? m_exp_found : m_res_found));
         chk("stuck", 32'(stuck), 32'(dn ? m_exp_stuck : m_res_stuck));
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_seed_val"}, 32'(seed_val), 32'd0);
      chk({tag, "_seed_out"}, 32'(seed_out), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_signature"}, 32'(signature), 32'd0);
      chk({tag, "_period"}, 32'(period), 32'd0);
      chk({tag, "_found"}, 32'(period_found), 32'd0);
      chk({tag, "_stuck"}, 32'(stuck), 32'd0);
   endtask

   task automatic run_bist(input logic [7:0] s, input bit stub, input logic [15:0] g, input bit dbl,
                           input int abort_c, input int rst_c,
                           output int lat, output int nd, output int nsv);
      lat = 0;
      nd = 0;
      nsv = 0;
      seed = s;
      use_stub = stub;
      golden_sig = g;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (seed_val) nsv++;
         if (done) begin
            nd++;
            if (lat == 0) lat = c;
         end
         if (abort_c != 0 && c == abort_c + 1) begin
            abort = 1'b0;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_seed_val", 32'(seed_val), 32'd0);
            chk("abort_pass", 32'(pass), 32'd0);
         end
         if (abort_c != 0 && c == abort_c) abort = 1'b1;
         if (dbl && c == 3) start = 1'b1;
         if (dbl && c == 4) start = 1'b0;
         if (rst_c != 0 && c == rst_c) begin
            #2 rst_n = 1'b0;
            #1 chk_all_zero("async_rst");
            rst_n = 1'b1;
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin : wdog
      #100000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : main
      int lat, nd, nsv;
      repeat (2) @(posedge clk);
      #1 chk_all_zero("reset");
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Real LFSR from FF: samples FF FE FC F8 F0, MISR 0AF0.
      run_bist(8'hFF, 1'b0, 16'h0AF0, 1'b0, 0, 0, lat, nd, nsv);
      chk("A_model_sig", 32'(m_exp_sig), 32'h0AF0);
      chk("A_latency", 32'(lat), 32'd7);
      chk("A_done_count", 32'(nd), 32'd1);
      chk("A_seed_val_count", 32'(nsv), 32'd1);
      chk("A_signature", 32'(signature), 32'h0AF0);
      chk("A_pass", 32'(pass), 32'd1);
      chk("A_stuck", 32'(stuck), 32'd0);
      chk("A_found", 32'(period_found), 32'd0);

      // Lock-up seed 00.
      run_bist(8'h00, 1'b0, 16'h0000, 1'b0, 0, 0, lat, nd, nsv);
      chk("B_signature", 32'(signature), 32'h0000);
      chk("B_pass", 32'(pass), 32'd1);
      chk("B_stuck", 32'(stuck), 32'd1);
      chk("B_period", 32'(period), 32'd1);
      chk("B_found", 32'(period_found), 32'd1);

      // Stub 11 22 33 11 22: MISR 00CC, period 3.
      run_bist(8'h11, 1'b1, 16'h00CC, 1'b0, 0, 0, lat, nd, nsv);
      chk("C_seed_val_count", 32'(nsv), 32'd1);
      chk("C_seed_out", 32'(seed_out), 32'h11);
      chk("C_signature", 32'(signature), 32'h00CC);
      chk("C_pass", 32'(pass), 32'd1);
      chk("C_period", 32'(period), 32'd3);
      chk("C_found", 32'(period_found), 32'd1);
      chk("C_stuck", 32'(stuck), 32'd0);

      // Wrong golden, plus a second start while busy.
      run_bist(8'h11, 1'b1, 16'h00CD, 1'b1, 0, 0, lat, nd, nsv);
      chk("D_pass", 32'(pass), 32'd0);
      chk("D_done_count", 32'(nd), 32'd1);
      chk("D_latency", 32'(lat), 32'd7);
      chk("D_busy_after", 32'(busy), 32'd0);

      // Abort on the third sampling cycle.
      run_bist(8'hFF, 1'b0, 16'h0AF0, 1'b0, 4, 0, lat, nd, nsv);
      chk("E_done_count", 32'(nd), 32'd0);
      chk("E_pass", 32'(pass), 32'd0);
      chk("E_signature", 32'(signature), 32'd0);

      // start and abort together in idle.
      @(posedge clk);
      #1 begin start = 1'b1; abort = 1'b1; end
      @(posedge clk);
      #1 begin start = 1'b0; abort = 1'b0; end
      @(negedge clk);
      chk("F_busy", 32'(busy), 32'd0);
      chk("F_seed_val", 32'(seed_val), 32'd0);

      // Async reset mid-sampling, then a clean run.
      run_bist(8'h11, 1'b1, 16'h00CC, 1'b0, 0, 4, lat, nd, nsv);
      chk("G_done_count", 32'(nd), 32'd0);
      run_bist(8'hFF, 1'b0, 16'h0AF0, 1'b0, 0, 0, lat, nd, nsv);
      chk("H_signature", 32'(signature), 32'h0AF0);
      chk("H_pass", 32'(pass), 32'd1);
      chk("H_latency", 32'(lat), 32'd7);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
